fb_write_arbiter: RTL and testbench

- Owns the framebuffer write port (port B: addr/data/we) and shares it between a clear engine, the block-renderer pixel stream and the HUD overlay writer (score/health/combo).
- Each frame it first sweeps the whole buffer with a background colour, then arbitrates renderer and HUD pixels round-robin until the next frame start.
- Sits between the pixel producers and the dual-port RGB buffer; the display read port is untouched.

---
 rtl/fb_pkg.sv | 13 +
 rtl/fb_write_arbiter_if.sv | 57 +++++
 rtl/fb_rr_arbiter2.sv | 37 +++
 rtl/fb_write_arbiter.sv | 116 +++++++++++
 tb/tb_fb_write_arbiter.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/fb_pkg.sv
// Shared types and default geometry for the framebuffer write arbiter.
package fb_pkg;

   localparam int unsigned FB_WIDTH_DEF  = 512;
   localparam int unsigned FB_HEIGHT_DEF = 384;

   typedef logic [11:0] pixel_t;

   typedef enum logic [1:0] {IDLE, CLEAR, DRAW} fb_arb_state_t;

   typedef enum logic {REQ_RND, REQ_HUD} requester_t;

endpackage

// File: rtl/fb_write_arbiter_if.sv
// Producer-side bus of the framebuffer write arbiter (renderer, HUD, write port, status).
// drop_count_out exists only when FB_ARB_STATS_EN is defined.
interface fb_write_arbiter_if
   import fb_pkg::*;
#(
   parameter int ADDR_W = 18
);
   // Handshake: a pixel transfers in any cycle where valid and ready are both high.
   // Producers hold valid, x, y and pixel stable until they see ready.
   logic              frame_start_in;
   pixel_t            clear_color_in;
   logic              rnd_valid_in;
   logic [10:0]       rnd_x_in;
   logic [9:0]        rnd_y_in;
   pixel_t            rnd_pixel_in;
   logic              rnd_ready_out;
   logic              hud_valid_in;
   logic [10:0]       hud_x_in;
   logic [9:0]        hud_y_in;
   pixel_t            hud_pixel_in;
   logic              hud_ready_out;
   logic [ADDR_W-1:0] fb_addr_out;
   pixel_t            fb_data_out;
   logic              fb_we_out;
   logic              busy_out;
   logic              clear_done_out;
   logic              overrun_out;
   fb_arb_state_t     state_out;
`ifdef FB_ARB_STATS_EN
   logic [15:0]       drop_count_out;
`endif

   modport slave (
      input  frame_start_in, clear_color_in,
      input  rnd_valid_in, rnd_x_in, rnd_y_in, rnd_pixel_in,
      input  hud_valid_in, hud_x_in, hud_y_in, hud_pixel_in,
`ifdef FB_ARB_STATS_EN
      output drop_count_out,
`endif
      output rnd_ready_out, hud_ready_out,
      output fb_addr_out, fb_data_out, fb_we_out,
      output busy_out, clear_done_out, overrun_out, state_out
   );

   modport master (
      output frame_start_in, clear_color_in,
      output rnd_valid_in, rnd_x_in, rnd_y_in, rnd_pixel_in,
      output hud_valid_in, hud_x_in, hud_y_in, hud_pixel_in,
`ifdef FB_ARB_STATS_EN
      input  drop_count_out,
`endif
      input  rnd_ready_out, hud_ready_out,
      input  fb_addr_out, fb_data_out, fb_we_out,
      input  busy_out, clear_done_out, overrun_out, state_out
   );

endinterface

// File: rtl/fb_rr_arbiter2.sv
// Two-requester round-robin: combinational one-hot readies, last grant held internally.
module fb_rr_arbiter2
   import fb_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic valid_rnd,
   input  logic valid_hud,
   output logic ready_rnd,
   output logic ready_hud
);

   requester_t last_grant;

   always_comb begin
      ready_rnd = 1'b0;
      ready_hud = 1'b0;
      if (en) begin
         if (valid_rnd && valid_hud) begin
            // Tie goes to whoever was not served last.
            if (last_grant == REQ_HUD) ready_rnd = 1'b1;
            else                       ready_hud = 1'b1;
         end else begin
            ready_rnd = valid_rnd;
            ready_hud = valid_hud;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst)            last_grant <= REQ_HUD;
      else if (ready_rnd) last_grant <= REQ_RND;
      else if (ready_hud) last_grant <= REQ_HUD;
   end

endmodule

// File: rtl/fb_write_arbiter.sv
// Framebuffer write-port owner: per-frame background sweep, then round-robin renderer/HUD pixels.
// Define FB_ARB_STATS_EN to add the saturating dropped-pixel counter.
module fb_write_arbiter
   import fb_pkg::*;
#(
   parameter int WIDTH  = FB_WIDTH_DEF,
   parameter int HEIGHT = FB_HEIGHT_DEF,
   parameter int ADDR_W = $clog2(WIDTH * HEIGHT)
)(
   input  logic            clk_in,
   input  logic            rst_in,
   fb_write_arbiter_if.slave bus
);

   localparam int X_SHIFT = $clog2(WIDTH);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WIDTH * HEIGHT - 1);

   fb_arb_state_t     state;
   logic [ADDR_W-1:0] clear_cnt;
   pixel_t            clear_color;

   logic              ready_rnd, ready_hud, grant_en, handshake, in_range;
   logic [10:0]       sel_x;
   logic [9:0]        sel_y;
   pixel_t            sel_pixel;
   logic [ADDR_W-1:0] pix_addr;

   // A frame start in DRAW wins over any pending pixel.
   assign grant_en = (state == DRAW) && !bus.frame_start_in;

   fb_rr_arbiter2 u_rr (
      .clk       (clk_in),
      .rst       (rst_in),
      .en        (grant_en),
      .valid_rnd (bus.rnd_valid_in),
      .valid_hud (bus.hud_valid_in),
      .ready_rnd (ready_rnd),
      .ready_hud (ready_hud)
   );

   assign bus.rnd_ready_out = ready_rnd;
   assign bus.hud_ready_out = ready_hud;
   assign bus.state_out     = state;

   assign handshake = ready_rnd | ready_hud;
   assign sel_x     = ready_rnd ? bus.rnd_x_in     : bus.hud_x_in;
   assign sel_y     = ready_rnd ? bus.rnd_y_in     : bus.hud_y_in;
   assign sel_pixel = ready_rnd ? bus.rnd_pixel_in : bus.hud_pixel_in;
   assign in_range  = (32'(sel_x) < WIDTH) && (32'(sel_y) < HEIGHT);
   assign pix_addr  = ADDR_W'((32'(sel_y) << X_SHIFT) + 32'(sel_x));

   // clear_cnt is the next sweep address to issue; the write on the port is registered.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state              <= IDLE;
         clear_cnt          <= '0;
         clear_color        <= '0;
         bus.fb_addr_out    <= '0;
         bus.fb_data_out    <= '0;
         bus.fb_we_out      <= 1'b0;
         bus.busy_out       <= 1'b0;
         bus.clear_done_out <= 1'b0;
         bus.overrun_out    <= 1'b0;
`ifdef FB_ARB_STATS_EN
         bus.drop_count_out <= '0;
`endif
      end else begin
         bus.fb_we_out      <= 1'b0;
         bus.clear_done_out <= 1'b0;
         bus.overrun_out    <= 1'b0;
         if (bus.frame_start_in) begin
            state              <= CLEAR;
            clear_color        <= bus.clear_color_in;
            bus.fb_addr_out    <= '0;
            bus.fb_data_out    <= bus.clear_color_in;
            bus.fb_we_out      <= 1'b1;
            bus.busy_out       <= 1'b1;
            bus.clear_done_out <= (LAST_ADDR == '0);
            bus.overrun_out    <= (state == CLEAR);
            clear_cnt          <= ADDR_W'(1);
`ifdef FB_ARB_STATS_EN
            bus.drop_count_out <= '0;
`endif
         end else begin
            case (state)
               IDLE: ;
               CLEAR: begin
                  if (bus.clear_done_out) begin
                     state        <= DRAW;
                     bus.busy_out <= 1'b0;
                  end else begin
                     bus.fb_addr_out    <= clear_cnt;
                     bus.fb_data_out    <= clear_color;
                     bus.fb_we_out      <= 1'b1;
                     bus.clear_done_out <= (clear_cnt == LAST_ADDR);
                     clear_cnt          <= clear_cnt + 1'b1;
                  end
               end
               DRAW: begin
                  if (handshake) begin
                     bus.fb_addr_out <= pix_addr;
                     bus.fb_data_out <= sel_pixel;
                     bus.fb_we_out   <= in_range;
`ifdef FB_ARB_STATS_EN
                     if (!in_range && bus.drop_count_out != 16'hFFFF)
                        bus.drop_count_out <= bus.drop_count_out + 16'd1;
`endif
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Directed + randomized bench for fb_write_arbiter on a 4x2 framebuffer.
// Drop-count checks are active when FB_ARB_STATS_EN is defined.
module tb_fb_write_arbiter;
   import fb_pkg::*;

   localparam int W  = 4;
   localparam int H  = 2;
   localparam int AW = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   fb_write_arbiter_if #(.ADDR_W(AW)) bus ();

   fb_write_arbiter #(.WIDTH(W), .HEIGHT(H), .ADDR_W(AW)) dut (
      .clk_in (clk),
      .rst_in (rst),
      .bus    (bus.slave)
   );

   int n_vec = 0;
   int n_err = 0;
   int sweep_writes = 0;

   // Reference state: who was served last, and dropped pixels this frame.
   bit last_was_hud = 1'b1;
   int exp_drops = 0;

   always @(posedge clk) if (bus.fb_we_out === 1'b1 && bus.busy_out === 1'b1) sweep_writes++;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_rnd(input bit v, input int x, input int y, input logic [11:0] p);
      bus.rnd_valid_in = v;
      bus.rnd_x_in     = 11'(x);
      bus.rnd_y_in     = 10'(y);
      bus.rnd_pixel_in = p;
   endtask

   task automatic set_hud(input bit v, input int x, input int y, input logic [11:0] p);
      bus.hud_valid_in = v;
      bus.hud_x_in     = 11'(x);
      bus.hud_y_in     = 10'(y);
      bus.hud_pixel_in = p;
   endtask

   // One DRAW cycle: predict grant from the round-robin rule, check readies, then the write.
   task automatic draw_step(output bit got_rnd, output bit got_hud);
      bit er, eh, rv, hv, ok;
      int x, y;
      logic [11:0] p;
      @(negedge clk);
      rv = bus.rnd_valid_in;
      hv = bus.hud_valid_in;
      er = 1'b0;
      eh = 1'b0;
      if (rv && hv) begin
         if (last_was_hud) er = 1'b1;
         else              eh = 1'b1;
      end else begin
         er = rv;
         eh = hv;
      end
      chk("rnd_ready", bus.rnd_ready_out, er);
      chk("hud_ready", bus.hud_ready_out, eh);
      chk("ready_onehot", bus.rnd_ready_out & bus.hud_ready_out, 0);
      x = er ? int'(bus.rnd_x_in) : int'(bus.hud_x_in);
      y = er ? int'(bus.rnd_y_in) : int'(bus.hud_y_in);
      p = er ? bus.rnd_pixel_in : bus.hud_pixel_in;
      ok = (x < W) && (y < H);
      if (er) last_was_hud = 1'b0;
      if (eh) last_was_hud = 1'b1;
      if ((er || eh) && !ok) exp_drops++;
      tick();
      chk("draw_we", bus.fb_we_out, (er || eh) && ok);
      if ((er || eh) && ok) begin
         chk("draw_addr", bus.fb_addr_out, (y * W + x) % (W * H));
         chk("draw_data", bus.fb_data_out, p);
      end
`ifdef FB_ARB_STATS_EN
      chk("drop_count", bus.drop_count_out, exp_drops);
`endif
      got_rnd = er;
      got_hud = eh;
   endtask

   initial begin
      bit gr, gh;
      bus.frame_start_in = 1'b0;
      bus.clear_color_in = '0;
      set_rnd(0, 0, 0, '0);
      set_hud(0, 0, 0, '0);

      // Reset
      repeat (3) tick();
      rst = 1'b0;
      @(negedge clk);
      chk("rst_state", bus.state_out, IDLE);
      chk("rst_we", bus.fb_we_out, 0);
      chk("rst_addr", bus.fb_addr_out, 0);
      chk("rst_data", bus.fb_data_out, 0);
      chk("rst_busy", bus.busy_out, 0);
      chk("rst_done", bus.clear_done_out, 0);
      chk("rst_overrun", bus.overrun_out, 0);
      chk("rst_ready", {bus.rnd_ready_out, bus.hud_ready_out}, 0);
`ifdef FB_ARB_STATS_EN
      chk("rst_drops", bus.drop_count_out, 0);
`endif

      // First frame: full sweep with 0F0
      tick();
      bus.frame_start_in = 1'b1;
      bus.clear_color_in = 12'h0F0;
      tick();
      bus.frame_start_in = 1'b0;
      exp_drops = 0;
      for (int i = 0; i < W * H; i++) begin
         chk("sweep_we", bus.fb_we_out, 1);
         chk("sweep_addr", bus.fb_addr_out, i);
         chk("sweep_data", bus.fb_data_out, 12'h0F0);
         chk("sweep_busy", bus.busy_out, 1);
         chk("sweep_done", bus.clear_done_out, i == W * H - 1);
         tick();
      end
      chk("after_sweep_state", bus.state_out, DRAW);
      chk("after_sweep_busy", bus.busy_out, 0);
      chk("after_sweep_we", bus.fb_we_out, 0);

      // Single renderer pixel at the last address
      set_rnd(1, 3, 1, 12'hF00);
      draw_step(gr, gh);
      set_rnd(0, 0, 0, '0);
      draw_step(gr, gh);

      // Both producers held for four cycles
      set_rnd(1, $urandom_range(0, W - 1), $urandom_range(0, H - 1), 12'($urandom));
      set_hud(1, $urandom_range(0, W - 1), $urandom_range(0, H - 1), 12'($urandom));
      for (int i = 0; i < 4; i++) begin
         draw_step(gr, gh);
         if (gr) set_rnd(1, $urandom_range(0, W - 1), $urandom_range(0, H - 1), 12'($urandom));
         if (gh) set_hud(1, $urandom_range(0, W - 1), $urandom_range(0, H - 1), 12'($urandom));
      end
      set_rnd(0, 0, 0, '0);
      set_hud(0, 0, 0, '0);

      // Out-of-range HUD pixel is accepted and dropped
      set_hud(1, 4, 0, 12'hABC);
      draw_step(gr, gh);
      chk("oor_accepted", gh, 1);
      set_hud(0, 0, 0, '0);

      // Random traffic, including out-of-range coordinates
      for (int i = 0; i < 300; i++) begin
         if (!bus.rnd_valid_in && $urandom_range(0, 2) != 0)
            set_rnd(1, $urandom_range(0, W + 1), $urandom_range(0, H), 12'($urandom));
         if (!bus.hud_valid_in && $urandom_range(0, 2) != 0)
            set_hud(1, $urandom_range(0, W + 1), $urandom_range(0, H), 12'($urandom));
         draw_step(gr, gh);
         if (gr) bus.rnd_valid_in = 1'b0;
         if (gh) bus.hud_valid_in = 1'b0;
      end

      // Frame start in DRAW blocks the pending renderer pixel
      set_rnd(1, 1, 0, 12'h123);
      bus.frame_start_in = 1'b1;
      bus.clear_color_in = 12'h00F;
      sweep_writes = 0;
      @(negedge clk);
      chk("fs_draw_rnd_ready", bus.rnd_ready_out, 0);
      chk("fs_draw_hud_ready", bus.hud_ready_out, 0);
      tick();
      bus.frame_start_in = 1'b0;
      set_rnd(0, 0, 0, '0);
      exp_drops = 0;
      chk("restart_we", bus.fb_we_out, 1);
      chk("restart_addr", bus.fb_addr_out, 0);
      chk("restart_data", bus.fb_data_out, 12'h00F);
      chk("restart_overrun", bus.overrun_out, 0);
`ifdef FB_ARB_STATS_EN
      chk("restart_drops", bus.drop_count_out, 0);
`endif
      tick();
      chk("second_addr", bus.fb_addr_out, 1);

      // Overrun: a new frame start where the third sweep write would be issued
      bus.frame_start_in = 1'b1;
      bus.clear_color_in = 12'hFFF;
      tick();
      bus.frame_start_in = 1'b0;
      chk("overrun_pulse", bus.overrun_out, 1);
      chk("overrun_addr", bus.fb_addr_out, 0);
      chk("overrun_data", bus.fb_data_out, 12'hFFF);
      set_rnd(1, 0, 0, 12'h111);
      set_hud(1, 1, 0, 12'h222);
      for (int i = 1; i < W * H; i++) begin
         tick();
         chk("resweep_addr", bus.fb_addr_out, i);
         chk("resweep_data", bus.fb_data_out, 12'hFFF);
         chk("resweep_overrun", bus.overrun_out, 0);
         @(negedge clk);
         chk("clear_ready", {bus.rnd_ready_out, bus.hud_ready_out}, 0);
      end
      set_rnd(0, 0, 0, '0);
      set_hud(0, 0, 0, '0);
      tick();
      chk("sweep_total", sweep_writes, 2 + W * H);
      chk("resweep_state", bus.state_out, DRAW);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
